// File: rtl/ptp_parser_gen.sv
// PTPv2 frame classifier: walks Ethernet/VLAN/MPLS/IPv4/IPv6/UDP headers on a
// 32-bit big-endian word stream and reports PTP header fields once per frame.
module ptp_parser_gen #(
  parameter int          MAX_VLAN       = 2,
  parameter int          MAX_MPLS       = 3,
  parameter bit          EN_L2          = 1'b1,
  parameter bit          EN_UDP4        = 1'b1,
  parameter bit          EN_UDP6        = 1'b1,
  parameter bit          ACCEPT_GENERAL = 1'b1,
  parameter logic [15:0] MSGID_MASK     = 16'h000F
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] in_data,
  input  logic        in_valid,
  input  logic        in_sop,
  input  logic        in_eop,
  input  logic [1:0]  in_mod,
  output logic        ptp_valid,
  output logic        ptp_found,
  output logic        ptp_l4,
  output logic        ptp_ipv6,
  output logic [3:0]  ptp_msgid,
  output logic [7:0]  ptp_domain,
  output logic        ptp_two_step,
  output logic [15:0] ptp_seqid,
  output logic [10:0] ptp_hdr_off,
  output logic        parse_err
);

  typedef enum logic [3:0] {
    S_IDLE, S_ETYPE, S_VLAN, S_MPLS, S_IPV4, S_IPV6, S_UDP, S_PTP, S_SKIP
  } state_t;

  state_t      state_q, state_d;
  logic [10:0] pos_q, pos_d;
  logic [11:0] hs_q, hs_d;
  logic [2:0]  vcnt_q, vcnt_d;
  logic [3:0]  mcnt_q, mcnt_d;
  logic        mbos_q, mbos_d;
  logic [3:0]  ihl_q, ihl_d;
  logic [7:0]  hi_q, hi_d;
  logic        l4_q, l4_d;
  logic        v6_q, v6_d;
  logic        done_q, done_d;
  logic        two_q, two_d;
  logic [3:0]  msg_q, msg_d;
  logic [3:0]  ver_q, ver_d;
  logic [7:0]  dom_q, dom_d;
  logic [15:0] seq_q, seq_d;

  logic        emit;
  logic        r_found_d, r_l4_d, r_v6_d, r_two_d, r_err_d;
  logic [3:0]  r_msg_d;
  logic [7:0]  r_dom_d;
  logic [15:0] r_seq_d;
  logic [10:0] r_off_d;

  logic        vld_q, found_q, l4o_q, v6o_q, twoo_q, err_q;
  logic [3:0]  msgo_q;
  logic [7:0]  domo_q;
  logic [15:0] seqo_q;
  logic [10:0] off_q;

  always_comb begin
    logic [7:0]  b;
    logic [11:0] p, o, sum;
    logic [15:0] et;
    int          nvalid;
    logic        is_ptp;
    b = '0; p = '0; o = '0; sum = '0; et = '0; nvalid = 4; is_ptp = 1'b0;
    state_d = state_q; pos_d = pos_q; hs_d = hs_q; vcnt_d = vcnt_q; mcnt_d = mcnt_q;
    mbos_d = mbos_q; ihl_d = ihl_q; hi_d = hi_q; l4_d = l4_q; v6_d = v6_q;
    done_d = done_q; two_d = two_q; msg_d = msg_q; ver_d = ver_q; dom_d = dom_q;
    seq_d = seq_q;
    emit = 1'b0;
    r_found_d = 1'b0; r_l4_d = 1'b0; r_v6_d = 1'b0; r_two_d = 1'b0; r_err_d = 1'b0;
    r_msg_d = '0; r_dom_d = '0; r_seq_d = '0; r_off_d = '0;

    if (in_valid) begin
      if (in_sop) begin
        state_d = S_ETYPE; pos_d = '0; hs_d = 12'd12; vcnt_d = '0; mcnt_d = '0;
        mbos_d = 1'b0; ihl_d = '0; hi_d = '0; l4_d = 1'b0; v6_d = 1'b0;
        done_d = 1'b0; two_d = 1'b0; msg_d = '0; ver_d = '0; dom_d = '0; seq_d = '0;
      end
      if (in_eop && in_mod != 2'd0) nvalid = 4 - int'(in_mod);

      if (state_d != S_IDLE) begin
        for (int i = 0; i < 4; i++) begin
          b   = in_data[31-8*i -: 8];
          sum = {1'b0, pos_d} + 12'(i);
          p   = (sum > 12'd2047) ? 12'd2047 : sum;
          o   = p - hs_d;
          if (i < nvalid) begin
            // Saturated position: any header not yet complete is out of reach
            if (p == 12'd2047 && state_d != S_SKIP && !(state_d == S_PTP && done_d))
              state_d = S_SKIP;
            // Bottom-of-stack MPLS payload is classified by its first nibble
            if (state_d == S_MPLS && mbos_d && o == 12'd0) begin
              if (b[7:4] == 4'd4)      state_d = S_IPV4;
              else if (b[7:4] == 4'd6) begin state_d = S_IPV6; v6_d = 1'b1; end
              else                     state_d = S_SKIP;
            end
            case (state_d)
              S_ETYPE: begin
                if (o == 12'd0) hi_d = b;
                else if (o == 12'd1) begin
                  et = {hi_d, b};
                  if (et == 16'h8100 || et == 16'h88A8 || et == 16'h9100) begin
                    if (int'(vcnt_d) >= MAX_VLAN) state_d = S_SKIP;
                    else begin vcnt_d = vcnt_d + 3'd1; state_d = S_VLAN; end
                  end else if (et == 16'h8847 || et == 16'h8848) begin
                    if (int'(mcnt_d) >= MAX_MPLS) state_d = S_SKIP;
                    else begin mcnt_d = mcnt_d + 4'd1; state_d = S_MPLS; hs_d = hs_d + 12'd2; end
                  end else if (et == 16'h0800 && EN_UDP4) begin
                    state_d = S_IPV4; hs_d = hs_d + 12'd2;
                  end else if (et == 16'h86DD && EN_UDP6) begin
                    state_d = S_IPV6; hs_d = hs_d + 12'd2; v6_d = 1'b1;
                  end else if (et == 16'h88F7 && EN_L2) begin
                    state_d = S_PTP; hs_d = hs_d + 12'd2;
                  end else state_d = S_SKIP;
                end
              end
              S_VLAN: if (o == 12'd3) begin state_d = S_ETYPE; hs_d = hs_d + 12'd4; end
              S_MPLS: begin
                if (o == 12'd2 && b[0]) mbos_d = 1'b1;
                else if (o == 12'd3) begin
                  hs_d = hs_d + 12'd4;
                  if (!mbos_d) begin
                    if (int'(mcnt_d) >= MAX_MPLS) state_d = S_SKIP;
                    else mcnt_d = mcnt_d + 4'd1;
                  end
                end
              end
              S_IPV4: begin
                if (o == 12'd0) begin
                  if (b[7:4] != 4'd4 || b[3:0] < 4'd5) state_d = S_SKIP;
                  else ihl_d = b[3:0];
                end else if (o == 12'd6) begin
                  if (b[5:0] != 6'd0) state_d = S_SKIP;
                end else if (o == 12'd7) begin
                  if (b != 8'd0) state_d = S_SKIP;
                end else if (o == 12'd9) begin
                  if (b != 8'd17) state_d = S_SKIP;
                end else if (o == {6'd0, ihl_d, 2'd0} - 12'd1) begin
                  state_d = S_UDP; hs_d = hs_d + {6'd0, ihl_d, 2'd0}; l4_d = 1'b1;
                end
              end
              S_IPV6: begin
                if (o == 12'd0) begin
                  if (b[7:4] != 4'd6) state_d = S_SKIP;
                end else if (o == 12'd6) begin
                  if (b != 8'd17) state_d = S_SKIP;
                end else if (o == 12'd39) begin
                  state_d = S_UDP; hs_d = hs_d + 12'd40; l4_d = 1'b1;
                end
              end
              S_UDP: begin
                if (o == 12'd2) hi_d = b;
                else if (o == 12'd3) begin
                  if (!({hi_d, b} == 16'd319 || (ACCEPT_GENERAL && {hi_d, b} == 16'd320)))
                    state_d = S_SKIP;
                end else if (o == 12'd7) begin
                  state_d = S_PTP; hs_d = hs_d + 12'd8;
                end
              end
              S_PTP: begin
                case (o)
                  12'd0:   msg_d = b[3:0];
                  12'd1:   ver_d = b[3:0];
                  12'd4:   dom_d = b;
                  12'd6:   two_d = b[1];
                  12'd30:  seq_d[15:8] = b;
                  12'd31:  seq_d[7:0] = b;
                  12'd33:  done_d = 1'b1;
                  default: ;
                endcase
              end
              default: ;
            endcase
          end
        end
        sum   = {1'b0, pos_d} + 12'd4;
        pos_d = sum[11] ? 11'h7FF : sum[10:0];

        if (in_eop) begin
          emit      = 1'b1;
          is_ptp    = (state_d == S_PTP);
          r_found_d = is_ptp && done_d && ver_d == 4'd2 && MSGID_MASK[msg_d];
          r_err_d   = is_ptp && !done_d;
          r_l4_d    = is_ptp && l4_d;
          r_v6_d    = is_ptp && l4_d && v6_d;
          if (is_ptp) begin
            r_msg_d = msg_d; r_dom_d = dom_d; r_two_d = two_d;
            r_seq_d = seq_d; r_off_d = hs_d[10:0];
          end
          state_d = S_IDLE;
        end
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE; pos_q <= '0; hs_q <= '0; vcnt_q <= '0; mcnt_q <= '0;
      mbos_q <= 1'b0; ihl_q <= '0; hi_q <= '0; l4_q <= 1'b0; v6_q <= 1'b0;
      done_q <= 1'b0; two_q <= 1'b0; msg_q <= '0; ver_q <= '0; dom_q <= '0; seq_q <= '0;
      vld_q <= 1'b0; found_q <= 1'b0; l4o_q <= 1'b0; v6o_q <= 1'b0; twoo_q <= 1'b0;
      err_q <= 1'b0; msgo_q <= '0; domo_q <= '0; seqo_q <= '0; off_q <= '0;
    end else begin
      state_q <= state_d; pos_q <= pos_d; hs_q <= hs_d; vcnt_q <= vcnt_d; mcnt_q <= mcnt_d;
      mbos_q <= mbos_d; ihl_q <= ihl_d; hi_q <= hi_d; l4_q <= l4_d; v6_q <= v6_d;
      done_q <= done_d; two_q <= two_d; msg_q <= msg_d; ver_q <= ver_d; dom_q <= dom_d;
      seq_q <= seq_d;
      vld_q <= emit;
      if (emit) begin
        found_q <= r_found_d; l4o_q <= r_l4_d; v6o_q <= r_v6_d; twoo_q <= r_two_d;
        err_q <= r_err_d; msgo_q <= r_msg_d; domo_q <= r_dom_d; seqo_q <= r_seq_d;
        off_q <= r_off_d;
      end
    end
  end

  assign ptp_valid    = vld_q;
  assign ptp_found    = found_q;
  assign ptp_l4       = l4o_q;
  assign ptp_ipv6     = v6o_q;
  assign ptp_msgid    = msgo_q;
  assign ptp_domain   = domo_q;
  assign ptp_two_step = twoo_q;
  assign ptp_seqid    = seqo_q;
  assign ptp_hdr_off  = off_q;
  assign parse_err    = err_q;

endmodule

// File: tb/tb_ptp_parser_gen.sv
// Directed bench for ptp_parser_gen: builds frames byte by byte and checks the
// per-frame result against hand-derived values.
module tb_ptp_parser_gen;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [31:0] in_data = '0;
  logic        in_valid = 1'b0, in_sop = 1'b0, in_eop = 1'b0;
  logic [1:0]  in_mod = '0;

  logic        ptp_valid, ptp_found, ptp_l4, ptp_ipv6, ptp_two_step, parse_err;
  logic [3:0]  ptp_msgid;
  logic [7:0]  ptp_domain;
  logic [15:0] ptp_seqid;
  logic [10:0] ptp_hdr_off;

  logic        ng_valid, ng_found, ng_l4, ng_ipv6, ng_two_step, ng_err;
  logic [3:0]  ng_msgid;
  logic [7:0]  ng_domain;
  logic [15:0] ng_seqid;
  logic [10:0] ng_hdr_off;

  int n_chk = 0;
  int n_fail = 0;
  int vcount = 0;
  int cnt0;

  logic [7:0] fr [0:255];
  int flen;

  ptp_parser_gen dut (
    .clk(clk), .rst(rst), .in_data(in_data), .in_valid(in_valid), .in_sop(in_sop),
    .in_eop(in_eop), .in_mod(in_mod), .ptp_valid(ptp_valid), .ptp_found(ptp_found),
    .ptp_l4(ptp_l4), .ptp_ipv6(ptp_ipv6), .ptp_msgid(ptp_msgid), .ptp_domain(ptp_domain),
    .ptp_two_step(ptp_two_step), .ptp_seqid(ptp_seqid), .ptp_hdr_off(ptp_hdr_off),
    .parse_err(parse_err)
  );

  ptp_parser_gen #(.ACCEPT_GENERAL(1'b0)) dut_ng (
    .clk(clk), .rst(rst), .in_data(in_data), .in_valid(in_valid), .in_sop(in_sop),
    .in_eop(in_eop), .in_mod(in_mod), .ptp_valid(ng_valid), .ptp_found(ng_found),
    .ptp_l4(ng_l4), .ptp_ipv6(ng_ipv6), .ptp_msgid(ng_msgid), .ptp_domain(ng_domain),
    .ptp_two_step(ng_two_step), .ptp_seqid(ng_seqid), .ptp_hdr_off(ng_hdr_off),
    .parse_err(ng_err)
  );

  always #5 clk = ~clk;

  always @(negedge clk) if (ptp_valid) vcount++;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    assert (got === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic new_frame(input int len, input logic [15:0] etype);
    for (int i = 0; i < 256; i++) fr[i] = 8'h00;
    for (int i = 0; i < 12; i++) fr[i] = 8'h20 + 8'(i);
    fr[12] = etype[15:8];
    fr[13] = etype[7:0];
    flen = len;
  endtask

  task automatic put16(input int off, input logic [15:0] v);
    fr[off] = v[15:8];
    fr[off+1] = v[7:0];
  endtask

  task automatic put_ptp(input int h, input logic [3:0] msg, input logic [7:0] dom,
                         input bit two, input logic [15:0] seq);
    fr[h] = {4'h0, msg};
    fr[h+1] = 8'h02;
    put16(h + 2, 16'd44);
    fr[h+4] = dom;
    fr[h+6] = two ? 8'h02 : 8'h00;
    put16(h + 30, seq);
  endtask

  task automatic put_ip4(input int s, input logic [3:0] ihl, input logic [7:0] flags);
    fr[s] = {4'h4, ihl};
    fr[s+6] = flags;
    fr[s+8] = 8'h40;
    fr[s+9] = 8'd17;
  endtask

  task automatic put_ip6(input int s);
    fr[s] = 8'h60;
    fr[s+6] = 8'd17;
    fr[s+7] = 8'h40;
  endtask

  task automatic put_udp(input int s, input logic [15:0] port);
    put16(s, 16'd5000);
    put16(s + 2, port);
  endtask

  task automatic send(input int nw, input bit eop, input bit stall);
    for (int w = 0; w < nw; w++) begin
      if (stall && (w % 3) == 1) begin
        in_valid = 1'b0; in_sop = 1'b1; in_eop = 1'b1; in_data = 32'hFFFF_FFFF;
        @(posedge clk); #1;
      end
      in_data  = {fr[4*w], fr[4*w+1], fr[4*w+2], fr[4*w+3]};
      in_valid = 1'b1;
      in_sop   = (w == 0);
      in_eop   = eop && (w == nw - 1);
      in_mod   = in_eop ? 2'((4 - flen % 4) % 4) : 2'd0;
      @(posedge clk); #1;
    end
    in_valid = 1'b0; in_sop = 1'b0; in_eop = 1'b0; in_mod = 2'd0; in_data = '0;
  endtask

  task automatic send_frame(input string tag, input bit stall);
    send((flen + 3) / 4, 1'b1, stall);
    chk({tag, ".vld"}, ptp_valid, 1);
  endtask

  task automatic chk_res(input string tag, input bit f, input bit l4, input bit v6,
                         input logic [3:0] msg, input logic [7:0] dom, input bit two,
                         input logic [15:0] seq, input logic [10:0] off, input bit err);
    chk({tag, ".found"}, ptp_found, f);
    chk({tag, ".l4"}, ptp_l4, l4);
    chk({tag, ".ipv6"}, ptp_ipv6, v6);
    chk({tag, ".msgid"}, ptp_msgid, msg);
    chk({tag, ".domain"}, ptp_domain, dom);
    chk({tag, ".two_step"}, ptp_two_step, two);
    chk({tag, ".seqid"}, ptp_seqid, seq);
    chk({tag, ".hdr_off"}, ptp_hdr_off, off);
    chk({tag, ".err"}, parse_err, err);
    @(posedge clk); #1;
    chk({tag, ".vld_low"}, ptp_valid, 0);
    chk({tag, ".hold"}, ptp_seqid, seq);
  endtask

  initial begin
    #2 rst = 1'b1;
    #1;
    chk("rst.valid", ptp_valid, 0);
    chk("rst.found", ptp_found, 0);
    chk("rst.seqid", ptp_seqid, 0);
    chk("rst.hdr_off", ptp_hdr_off, 0);
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(posedge clk); #1;

    // untagged L2 Sync
    new_frame(64, 16'h88F7);
    put_ptp(14, 4'd0, 8'h05, 1'b0, 16'h1234);
    send_frame("l2sync", 1'b0);
    chk_res("l2sync", 1, 0, 0, 4'd0, 8'h05, 0, 16'h1234, 11'd14, 0);

    // QinQ + IPv4 UDP 319 Delay_Req, with stall cycles
    new_frame(90, 16'h88A8);
    put16(14, 16'h0064); put16(16, 16'h8100); put16(18, 16'h00C8); put16(20, 16'h0800);
    put_ip4(22, 4'd5, 8'h00); put_udp(42, 16'd319);
    put_ptp(50, 4'd1, 8'h18, 1'b0, 16'h0042);
    send_frame("qinq4", 1'b1);
    chk_res("qinq4", 1, 1, 0, 4'd1, 8'h18, 0, 16'h0042, 11'd50, 0);

    // three tags exceeds MAX_VLAN=2
    new_frame(94, 16'h88A8);
    put16(16, 16'h8100); put16(20, 16'h8100); put16(24, 16'h0800);
    put_ip4(26, 4'd5, 8'h00); put_udp(46, 16'd319);
    put_ptp(54, 4'd1, 8'h18, 1'b0, 16'h0042);
    send_frame("vlan3", 1'b0);
    chk_res("vlan3", 0, 0, 0, 4'd0, 8'h00, 0, 16'h0000, 11'd0, 0);

    // IPv4 IHL 6, two-step
    new_frame(83, 16'h0800);
    put_ip4(14, 4'd6, 8'h00); put_udp(38, 16'd319);
    put_ptp(46, 4'd2, 8'h7F, 1'b1, 16'hBEEF);
    send_frame("ihl6", 1'b0);
    chk_res("ihl6", 1, 1, 0, 4'd2, 8'h7F, 1, 16'hBEEF, 11'd46, 0);

    // same with MF set
    fr[20] = 8'h20;
    send_frame("mf", 1'b0);
    chk_res("mf", 0, 0, 0, 4'd0, 8'h00, 0, 16'h0000, 11'd0, 0);

    // IPv6 UDP 320 Follow_Up: masked msgid
    new_frame(100, 16'h86DD);
    put_ip6(14); put_udp(54, 16'd320);
    put_ptp(62, 4'd8, 8'h03, 1'b0, 16'h0777);
    send_frame("ip6fu", 1'b0);
    chk("ng.vld", ng_valid, 1);
    chk("ng.found", ng_found, 0);
    chk("ng.msgid", ng_msgid, 0);
    chk("ng.l4", ng_l4, 0);
    chk("ng.ipv6", ng_ipv6, 0);
    chk("ng.hdr_off", ng_hdr_off, 0);
    chk_res("ip6fu", 0, 1, 1, 4'd8, 8'h03, 0, 16'h0777, 11'd62, 0);

    // L2 PTP truncated at PTP byte 30
    new_frame(45, 16'h88F7);
    put_ptp(14, 4'd0, 8'h05, 1'b0, 16'h0034);
    send_frame("trunc", 1'b0);
    chk("trunc.found", ptp_found, 0);
    chk("trunc.err", parse_err, 1);
    chk("trunc.hdr_off", ptp_hdr_off, 14);
    chk("trunc.l4", ptp_l4, 0);
    @(posedge clk); #1;
    chk("trunc.vld_low", ptp_valid, 0);

    // MPLS single label to IPv4/UDP
    new_frame(81, 16'h8847);
    fr[14] = 8'h00; fr[15] = 8'h01; fr[16] = 8'h01; fr[17] = 8'h40;
    put_ip4(18, 4'd5, 8'h00); put_udp(38, 16'd319);
    put_ptp(46, 4'd3, 8'h11, 1'b0, 16'hCAFE);
    send_frame("mpls", 1'b0);
    chk_res("mpls", 1, 1, 0, 4'd3, 8'h11, 0, 16'hCAFE, 11'd46, 0);

    // ARP: not PTP
    new_frame(64, 16'h0806);
    send_frame("arp", 1'b0);
    chk_res("arp", 0, 0, 0, 4'd0, 8'h00, 0, 16'h0000, 11'd0, 0);

    // SOP and EOP on the same word
    new_frame(4, 16'h88F7);
    send_frame("oneword", 1'b0);
    chk_res("oneword", 0, 0, 0, 4'd0, 8'h00, 0, 16'h0000, 11'd0, 0);

    // restart mid-frame, reset mid-frame, then a clean Sync
    new_frame(64, 16'h88F7);
    put_ptp(14, 4'd0, 8'h05, 1'b0, 16'h1111);
    send_frame("pre", 1'b0);
    chk_res("pre", 1, 0, 0, 4'd0, 8'h05, 0, 16'h1111, 11'd14, 0);
    cnt0 = vcount;
    send(5, 1'b0, 1'b0);
    put16(44, 16'h3333);
    send(4, 1'b0, 1'b0);
    rst = 1'b1;
    #1;
    chk("arst.found", ptp_found, 0);
    chk("arst.seqid", ptp_seqid, 0);
    chk("arst.hdr_off", ptp_hdr_off, 0);
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;
    put16(44, 16'h2222);
    send_frame("clean", 1'b0);
    chk_res("clean", 1, 0, 0, 4'd0, 8'h05, 0, 16'h2222, 11'd14, 0);
    chk("clean.pulses", 32'(vcount - cnt0), 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
